// File: rtl/sdio_pkg.sv
// rtl/sdio_pkg.sv - shared types and constants for the sdio channel mux
package sdio_pkg;

    localparam int CHW = 3;
    localparam logic [7:0] SDCLK_IDLE = 8'h00;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_GUARD  = 2'd2
    } state_t;

    typedef logic [CHW-1:0] ch_t;

endpackage

// File: rtl/sdio_chmux_if.sv
// rtl/sdio_chmux_if.sv - core-side select handshake and PHY bus of the channel mux
interface sdio_chmux_if;
    import sdio_pkg::*;

    logic           i_sel_valid;
    logic [CHW-1:0] i_sel_ch;
    logic           o_sel_ready;
    logic           o_sel_err;
    logic [CHW-1:0] o_cur_ch;

    logic [7:0]     i_sdclk;
    logic           i_cmd_en;
    logic           i_data_en;
    logic           i_rx_en;
    logic           i_pp_cmd;
    logic           i_pp_data;
    logic [1:0]     i_cmd_data;
    logic [31:0]    i_tx_data;

    logic [1:0]     o_cmd_strb;
    logic [1:0]     o_cmd_data;
    logic [1:0]     o_rx_strb;
    logic [15:0]    o_rx_data;
    logic           o_card_busy;

    modport master (
        output i_sel_valid, i_sel_ch, i_sdclk, i_cmd_en, i_data_en, i_rx_en,
               i_pp_cmd, i_pp_data, i_cmd_data, i_tx_data,
        input  o_sel_ready, o_sel_err, o_cur_ch, o_cmd_strb, o_cmd_data,
               o_rx_strb, o_rx_data, o_card_busy
    );

    modport slave (
        input  i_sel_valid, i_sel_ch, i_sdclk, i_cmd_en, i_data_en, i_rx_en,
               i_pp_cmd, i_pp_data, i_cmd_data, i_tx_data,
        output o_sel_ready, o_sel_err, o_cur_ch, o_cmd_strb, o_cmd_data,
               o_rx_strb, o_rx_data, o_card_busy
    );

endinterface

// File: rtl/sdio_cdetect.sv
// rtl/sdio_cdetect.sv - card-detect synchroniser and debounce for one channel
module sdio_cdetect
#(
    parameter int LGDEBOUNCE = 16
)
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_present,
    output logic o_change
);

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  present_q, present_d;
    logic [LGDEBOUNCE-1:0] cnt_q, cnt_d;

    // Any disagreement restarts the stability window; a full window commits.
    always_comb begin
        sync1_d   = i_raw;
        sync2_d   = sync1_q;
        present_d = present_q;
        cnt_d     = '0;
        o_change  = 1'b0;
        if (sync2_q != present_q) begin
            if (&cnt_q) begin
                present_d = sync2_q;
                o_change  = 1'b1;
            end else begin
                cnt_d = cnt_q + LGDEBOUNCE'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            present_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            present_q <= present_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_present = present_q;

endmodule

// File: rtl/sdio_chmux.sv
// rtl/sdio_chmux.sv - PHY-side switch connecting one sdio core to NUMCH front ends
module sdio_chmux
    import sdio_pkg::*;
#(
    parameter int NUMCH      = 2,
    parameter int NUMIO      = 4,
    parameter int GUARD      = 8,
    parameter int LGDEBOUNCE = 16
)
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    sdio_chmux_if.slave           bus,

    output logic [8*NUMCH-1:0]    o_ch_sdclk,
    output logic [NUMCH-1:0]      o_ch_cmd_en,
    output logic [NUMCH-1:0]      o_ch_data_en,
    output logic [NUMCH-1:0]      o_ch_rx_en,
    output logic                  o_ch_pp_cmd,
    output logic                  o_ch_pp_data,
    output logic [1:0]            o_ch_cmd_data,
    output logic [31:0]           o_ch_tx_data,

    input  logic [2*NUMCH-1:0]    i_ch_cmd_strb,
    input  logic [2*NUMCH-1:0]    i_ch_cmd_data,
    input  logic [2*NUMCH-1:0]    i_ch_rx_strb,
    input  logic [16*NUMCH-1:0]   i_ch_rx_data,
    input  logic [NUMCH-1:0]      i_ch_busy,

    input  logic [NUMCH-1:0]      i_card_detect,
    output logic [NUMCH-1:0]      o_card_present,
    output logic                  o_int
);

    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

    if (NUMCH < 1 || NUMCH > 8) begin : g_bad_numch
        $error("sdio_chmux: NUMCH must be 1..8");
    end
    if (GUARD < 1) begin : g_bad_guard
        $error("sdio_chmux: GUARD must be at least 1");
    end
    if (NUMIO != 1 && NUMIO != 4 && NUMIO != 8) begin : g_bad_numio
        $error("sdio_chmux: NUMIO must be 1, 4 or 8");
    end

    state_t         state_q, state_d;
    ch_t            cur_ch_q, cur_ch_d;
    ch_t            next_ch_q, next_ch_d;
    logic [GW-1:0]  gcnt_q, gcnt_d;
    logic           sel_ready_q, sel_ready_d;
    logic           sel_err_q, sel_err_d;
    logic           int_q, int_d;

    logic           ch_busy_cur;
    logic           bus_idle;
    logic           link_live;
    logic [1:0]     cmd_strb_mux, cmd_data_mux, rx_strb_mux;
    logic [15:0]    rx_data_mux;
    logic [NUMCH-1:0] present;
    logic [NUMCH-1:0] change;

    // Return path is a pure mux on the registered channel: no added latency.
    always_comb begin
        cmd_strb_mux = '0;
        cmd_data_mux = '0;
        rx_strb_mux  = '0;
        rx_data_mux  = '0;
        ch_busy_cur  = 1'b0;
        for (int ch = 0; ch < NUMCH; ch++) begin
            if (cur_ch_q == CHW'(ch)) begin
                cmd_strb_mux = i_ch_cmd_strb[2*ch +: 2];
                cmd_data_mux = i_ch_cmd_data[2*ch +: 2];
                rx_strb_mux  = i_ch_rx_strb[2*ch +: 2];
                rx_data_mux  = i_ch_rx_data[16*ch +: 16];
                ch_busy_cur  = i_ch_busy[ch];
            end
        end
    end

    assign link_live = (state_q != ST_GUARD);

    always_comb begin
        o_ch_sdclk   = '0;
        o_ch_cmd_en  = '0;
        o_ch_data_en = '0;
        o_ch_rx_en   = '0;
        for (int ch = 0; ch < NUMCH; ch++) begin
            o_ch_sdclk[8*ch +: 8] = SDCLK_IDLE;
            if (link_live && cur_ch_q == CHW'(ch)) begin
                o_ch_sdclk[8*ch +: 8] = bus.i_sdclk;
                o_ch_cmd_en[ch]       = bus.i_cmd_en;
                o_ch_data_en[ch]      = bus.i_data_en;
                o_ch_rx_en[ch]        = bus.i_rx_en;
            end
        end
    end

    assign bus_idle = !bus.i_cmd_en && !bus.i_data_en && !bus.i_rx_en && !ch_busy_cur;

    always_comb begin
        state_d   = state_q;
        cur_ch_d  = cur_ch_q;
        next_ch_d = next_ch_q;
        gcnt_d    = gcnt_q;
        sel_err_d = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (bus.i_sel_valid && sel_ready_q) begin
                    if (32'(bus.i_sel_ch) >= NUMCH) begin
                        sel_err_d = 1'b1;
                    end else if (bus.i_sel_ch != cur_ch_q) begin
                        next_ch_d = bus.i_sel_ch;
                        state_d   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus_idle) begin
                    state_d = ST_GUARD;
                    gcnt_d  = GW'(GUARD - 1);
                end
            end
            ST_GUARD: begin
                if (gcnt_q == '0) begin
                    cur_ch_d = next_ch_q;
                    state_d  = ST_ACTIVE;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
        sel_ready_d = (state_d == ST_ACTIVE);
        int_d       = |change;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_ACTIVE;
            cur_ch_q    <= '0;
            next_ch_q   <= '0;
            gcnt_q      <= '0;
            sel_ready_q <= 1'b1;
            sel_err_q   <= 1'b0;
            int_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            next_ch_q   <= next_ch_d;
            gcnt_q      <= gcnt_d;
            sel_ready_q <= sel_ready_d;
            sel_err_q   <= sel_err_d;
            int_q       <= int_d;
        end
    end

    for (genvar ch = 0; ch < NUMCH; ch++) begin : g_cdet
        sdio_cdetect #(
            .LGDEBOUNCE (LGDEBOUNCE)
        ) u_cdet (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_raw     (i_card_detect[ch]),
            .o_present (present[ch]),
            .o_change  (change[ch])
        );
    end

    assign o_card_present  = present;
    assign o_int           = int_q;

    assign o_ch_pp_cmd     = bus.i_pp_cmd;
    assign o_ch_pp_data    = bus.i_pp_data;
    assign o_ch_cmd_data   = bus.i_cmd_data;
    assign o_ch_tx_data    = bus.i_tx_data;

    assign bus.o_sel_ready = sel_ready_q;
    assign bus.o_sel_err   = sel_err_q;
    assign bus.o_cur_ch    = cur_ch_q;
    assign bus.o_cmd_strb  = cmd_strb_mux;
    assign bus.o_cmd_data  = cmd_data_mux;
    assign bus.o_rx_strb   = rx_strb_mux;
    assign bus.o_rx_data   = rx_data_mux;
    assign bus.o_card_busy = ch_busy_cur || (state_q != ST_ACTIVE);

endmodule

// File: tb/tb_sdio_chmux.sv
// tb/tb_sdio_chmux.sv - self-checking bench for sdio_chmux
module tb_sdio_chmux;
    import sdio_pkg::*;

    localparam int NUMCH = 2;
    localparam int GUARD = 8;
    localparam int LGDEB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdio_chmux_if bus();

    logic [15:0] ch_sdclk;
    logic [1:0]  ch_cmd_en, ch_data_en, ch_rx_en;
    logic        bc_pp_cmd, bc_pp_data;
    logic [1:0]  bc_cmd_data;
    logic [31:0] bc_tx_data;
    logic [3:0]  ch_cmd_strb, ch_cmd_data, ch_rx_strb;
    logic [31:0] ch_rx_data;
    logic [1:0]  ch_busy, cd, present;
    logic        irq;

    sdio_chmux #(
        .NUMCH(NUMCH), .NUMIO(4), .GUARD(GUARD), .LGDEBOUNCE(LGDEB)
    ) dut (
        .i_clk(clk), .i_reset(rst), .bus(bus),
        .o_ch_sdclk(ch_sdclk), .o_ch_cmd_en(ch_cmd_en), .o_ch_data_en(ch_data_en),
        .o_ch_rx_en(ch_rx_en), .o_ch_pp_cmd(bc_pp_cmd), .o_ch_pp_data(bc_pp_data),
        .o_ch_cmd_data(bc_cmd_data), .o_ch_tx_data(bc_tx_data),
        .i_ch_cmd_strb(ch_cmd_strb), .i_ch_cmd_data(ch_cmd_data), .i_ch_rx_strb(ch_rx_strb),
        .i_ch_rx_data(ch_rx_data), .i_ch_busy(ch_busy),
        .i_card_detect(cd), .o_card_present(present), .o_int(irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [7:0]  sdclk;
        logic [2:0]  en;
        logic [1:0]  busy;
        logic [31:0] rxd;
        logic [3:0]  rxs;
        logic [15:0] e_sdclk;
        logic [1:0]  e_cmd_en;
        logic [1:0]  e_data_en;
        logic        e_busy;
        logic [15:0] e_rxd;
        logic [1:0]  e_rxs;
    } vec_t;

    vec_t tbl[4];

    int m_cur, m_pend, m_gleft;
    logic m_err;

    task automatic model_step();
        logic nerr;
        nerr = 1'b0;
        if (m_pend < 0) begin
            if (bus.i_sel_valid) begin
                if (int'(bus.i_sel_ch) >= NUMCH) nerr = 1'b1;
                else if (int'(bus.i_sel_ch) != m_cur) m_pend = int'(bus.i_sel_ch);
            end
        end else if (m_gleft == 0) begin
            if (!bus.i_cmd_en && !bus.i_data_en && !bus.i_rx_en && !ch_busy[m_cur])
                m_gleft = GUARD;
        end else begin
            m_gleft--;
            if (m_gleft == 0) begin
                m_cur  = m_pend;
                m_pend = -1;
            end
        end
        m_err = nerr;
    endtask

    task automatic model_check();
        logic [15:0] e_clk;
        logic [1:0]  e_cmd, e_dat, e_rx;
        e_clk = '0; e_cmd = '0; e_dat = '0; e_rx = '0;
        for (int ch = 0; ch < NUMCH; ch++) begin
            if (ch == m_cur && m_gleft == 0) begin
                e_clk[8*ch +: 8] = bus.i_sdclk;
                e_cmd[ch] = bus.i_cmd_en;
                e_dat[ch] = bus.i_data_en;
                e_rx[ch]  = bus.i_rx_en;
            end
        end
        chk("rnd_cur_ch", bus.o_cur_ch, m_cur);
        chk("rnd_ready", bus.o_sel_ready, m_pend < 0);
        chk("rnd_sel_err", bus.o_sel_err, m_err);
        chk("rnd_sdclk", ch_sdclk, e_clk);
        chk("rnd_cmd_en", ch_cmd_en, e_cmd);
        chk("rnd_data_en", ch_data_en, e_dat);
        chk("rnd_rx_en", ch_rx_en, e_rx);
        chk("rnd_card_busy", bus.o_card_busy, ch_busy[m_cur] || (m_pend >= 0));
        chk("rnd_rx_data", bus.o_rx_data, ch_rx_data[16*m_cur +: 16]);
        chk("rnd_cmd_strb", bus.o_cmd_strb, ch_cmd_strb[2*m_cur +: 2]);
        chk("rnd_tx_bcast", bc_tx_data, bus.i_tx_data);
        chk("rnd_present", present, 2'b00);
    endtask

    task automatic count_guard(input string name, output int zeros);
        bit done;
        zeros = 0;
        done  = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            cyc();
            if (ch_sdclk == 16'h0000) zeros++;
            else done = 1;
        end
        chk({name, "_timeout"}, done, 1'b1);
    endtask

    initial begin
        int zeros, lat, pulses;
        bit found;

        tbl[0] = '{8'hFC, 3'b000, 2'b00, 32'hBEEF_1234, 4'b1001, 16'h00FC, 2'b00, 2'b00, 1'b0, 16'h1234, 2'b01};
        tbl[1] = '{8'h0F, 3'b111, 2'b10, 32'h5555_AAAA, 4'b0011, 16'h000F, 2'b01, 2'b01, 1'b0, 16'hAAAA, 2'b11};
        tbl[2] = '{8'hA5, 3'b010, 2'b01, 32'h0000_FFFF, 4'b1100, 16'h00A5, 2'b00, 2'b01, 1'b1, 16'hFFFF, 2'b00};
        tbl[3] = '{8'h00, 3'b100, 2'b11, 32'h1357_2468, 4'b0110, 16'h0000, 2'b01, 2'b00, 1'b1, 16'h2468, 2'b10};

        rst = 1'b1;
        bus.i_sel_valid = 0; bus.i_sel_ch = 0; bus.i_sdclk = 8'hFC;
        bus.i_cmd_en = 0; bus.i_data_en = 0; bus.i_rx_en = 0;
        bus.i_pp_cmd = 0; bus.i_pp_data = 0; bus.i_cmd_data = 0; bus.i_tx_data = 0;
        ch_cmd_strb = 0; ch_cmd_data = 0; ch_rx_strb = 0; ch_rx_data = 0;
        ch_busy = 0; cd = 0;
        cyc(); cyc();
        rst = 1'b0;
        #2;
        chk("rst_cur_ch", bus.o_cur_ch, 0);
        chk("rst_ready", bus.o_sel_ready, 1'b1);
        chk("rst_sel_err", bus.o_sel_err, 1'b0);
        chk("rst_int", irq, 1'b0);
        chk("rst_present", present, 2'b00);
        chk("rst_sdclk", ch_sdclk, 16'h00FC);

        // Table: combinational forward/return paths with channel 0 connected.
        for (int k = 0; k < 4; k++) begin
            bus.i_sdclk = tbl[k].sdclk;
            {bus.i_cmd_en, bus.i_data_en, bus.i_rx_en} = tbl[k].en;
            ch_busy = tbl[k].busy;
            ch_rx_data = tbl[k].rxd;
            ch_rx_strb = tbl[k].rxs;
            #1;
            chk("tbl_sdclk", ch_sdclk, tbl[k].e_sdclk);
            chk("tbl_cmd_en", ch_cmd_en, tbl[k].e_cmd_en);
            chk("tbl_data_en", ch_data_en, tbl[k].e_data_en);
            chk("tbl_busy", bus.o_card_busy, tbl[k].e_busy);
            chk("tbl_rx_data", bus.o_rx_data, tbl[k].e_rxd);
            chk("tbl_rx_strb", bus.o_rx_strb, tbl[k].e_rxs);
            cyc();
        end
        bus.i_sdclk = 8'hFC; bus.i_cmd_en = 0; bus.i_data_en = 0; bus.i_rx_en = 0;
        ch_busy = 0; ch_rx_data = 0; ch_rx_strb = 0;
        cyc();

        // Switch to ch1 while a data transfer holds the bus.
        bus.i_data_en = 1; bus.i_sel_valid = 1; bus.i_sel_ch = 1;
        cyc();
        bus.i_sel_valid = 0;
        for (int i = 0; i < 20; i++) begin
            chk("drain_ready", bus.o_sel_ready, 1'b0);
            chk("drain_busy", bus.o_card_busy, 1'b1);
            chk("drain_sdclk", ch_sdclk, 16'h00FC);
            chk("drain_cur", bus.o_cur_ch, 0);
            cyc();
        end
        bus.i_data_en = 0;
        #1;
        chk("drain_last_sdclk", ch_sdclk, 16'h00FC);
        count_guard("guard1", zeros);
        chk("guard1_len", zeros, GUARD);
        chk("sw1_cur", bus.o_cur_ch, 1);
        chk("sw1_sdclk", ch_sdclk, 16'hFC00);
        chk("sw1_ready", bus.o_sel_ready, 1'b1);

        // Switch back to ch0 while ch1 reports busy.
        ch_busy = 2'b10; bus.i_sel_valid = 1; bus.i_sel_ch = 0;
        cyc();
        bus.i_sel_valid = 0;
        for (int i = 0; i < 10; i++) begin
            chk("busyw_busy", bus.o_card_busy, 1'b1);
            chk("busyw_sdclk", ch_sdclk, 16'hFC00);
            cyc();
        end
        ch_busy = 2'b00;
        #1;
        chk("busyw_last_sdclk", ch_sdclk, 16'hFC00);
        count_guard("guard2", zeros);
        chk("guard2_len", zeros, GUARD);
        chk("sw2_cur", bus.o_cur_ch, 0);
        chk("sw2_sdclk", ch_sdclk, 16'h00FC);

        // Out-of-range request.
        bus.i_sel_valid = 1; bus.i_sel_ch = 5;
        cyc();
        bus.i_sel_valid = 0;
        chk("err_pulse", bus.o_sel_err, 1'b1);
        chk("err_cur", bus.o_cur_ch, 0);
        chk("err_ready", bus.o_sel_ready, 1'b1);
        chk("err_sdclk", ch_sdclk, 16'h00FC);
        cyc();
        chk("err_pulse_end", bus.o_sel_err, 1'b0);

        // Card detect bounce then settle.
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 0) cd[1] = ~cd[1];
            #1;
            chk("bounce_present", present, 2'b00);
            pulses += int'(irq);
            cyc();
        end
        chk("bounce_int", pulses, 0);
        cd[1] = 1'b1;
        found = 0; lat = 0; pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            pulses += int'(irq);
            if (!found && present[1]) begin
                found = 1;
                lat = i + 1;
                chk("cd_int_with_present", irq, 1'b1);
            end
        end
        chk("cd_found", found, 1'b1);
        chk("cd_latency", (lat >= 17 && lat <= 19), 1'b1);
        chk("cd_int_pulses", pulses, 1);
        chk("cd_present", present, 2'b10);

        // Reset in the middle of a guard period.
        cd = 2'b00;
        bus.i_sel_valid = 1; bus.i_sel_ch = 1;
        cyc();
        bus.i_sel_valid = 0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("rg_guard_sdclk", ch_sdclk, 16'h0000);
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rg_cur", bus.o_cur_ch, 0);
        chk("rg_ready", bus.o_sel_ready, 1'b1);
        chk("rg_sdclk", ch_sdclk, 16'h00FC);
        chk("rg_busy", bus.o_card_busy, 1'b0);
        chk("rg_present", present, 2'b00);
        chk("rg_int", irq, 1'b0);

        // Randomized traffic against the reference model.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_cur = 0; m_pend = -1; m_gleft = 0; m_err = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            bus.i_sdclk     = 8'($urandom);
            bus.i_cmd_en    = ($urandom % 4) == 0;
            bus.i_data_en   = ($urandom % 4) == 0;
            bus.i_rx_en     = ($urandom % 4) == 0;
            bus.i_pp_cmd    = 1'($urandom);
            bus.i_pp_data   = 1'($urandom);
            bus.i_cmd_data  = 2'($urandom);
            bus.i_tx_data   = $urandom;
            bus.i_sel_valid = ($urandom % 8) == 0;
            bus.i_sel_ch    = 3'($urandom % 4);
            ch_busy[0]      = ($urandom % 4) == 0;
            ch_busy[1]      = ($urandom % 4) == 0;
            ch_cmd_strb     = 4'($urandom);
            ch_cmd_data     = 4'($urandom);
            ch_rx_strb      = 4'($urandom);
            ch_rx_data      = $urandom;
            #1;
            model_check();
            @(posedge clk);
            model_step();
            #2;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
